sample_serializer: RTL and testbench

SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

---
 rtl/filter_pkg.sv | 12 +
 rtl/sample_fifo.sv | 57 +++++
 rtl/sample_serializer.sv | 114 +++++++++++
 tb/tb_sample_serializer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// filter_pkg -- constants and types shared by filter_pipeline and the
// serializer that feeds the DAC.
package filter_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH = 24;
  localparam int DEFAULT_SLOT_WIDTH   = 32;
  localparam int SAMPLE_FIFO_DEPTH    = 2;

  // One filtered sample as produced by filter_pipeline.sample_out.
  typedef logic [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo -- two-entry FIFO between filter_pipeline and the serializer.
// A push while full and a pop while empty are both ignored.
module sample_fifo
  import filter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_SAMPLE_WIDTH
) (
  input  logic             sample_clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [SAMPLE_FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == 2'(SAMPLE_FIFO_DEPTH));
  assign empty    = (count == 2'd0);
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointer and fill-count bookkeeping.
  always_ff @(posedge sample_clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Sample storage.
  // NOTE: storage is deliberately left out of reset; the count alone decides
  // which entries are meaningful, so clearing data would only add reset fanout.
  always_ff @(posedge sample_clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sample_serializer.sv
// sample_serializer -- buffers filtered samples and shifts them out as mono
// I2S (same sample in left and right slots), MSB first, one bit of delay
// after each lrclk transition. One sample is consumed per frame.
module sample_serializer
  import filter_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = DEFAULT_SLOT_WIDTH,
  parameter int BCLK_HALF    = 4
) (
  input  logic                    sample_clock,
  input  logic                    reset_n,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
  localparam int PAD   = SLOT_WIDTH - SAMPLE_WIDTH;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_WIDTH);
  localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] LR_LAST  = BIT_W'(2 * SLOT_WIDTH - 2);

  logic [DIV_W-1:0]        div_q;
  logic [BIT_W-1:0]        bit_q;
  logic [BIT_W-1:0]        bit_d;
  logic [BIT_W-1:0]        slot_pos;
  logic [SAMPLE_WIDTH-1:0] frame_q;
  logic [SAMPLE_WIDTH-1:0] frame_d;
  logic [SLOT_WIDTH-1:0]   slot_word;
  logic [SAMPLE_WIDTH-1:0] fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fall;
  logic                    boundary;
  logic                    push;
  logic                    pop;
  logic                    lr_d;
  logic                    sdata_d;

  assign sample_ready = !fifo_full;
  assign push         = sample_valid && sample_ready;
  assign fall         = bclk && (div_q == DIV_LAST);
  assign boundary     = fall && (bit_q == BIT_LAST);
  assign pop          = boundary && !fifo_empty;

  sample_fifo #(.WIDTH(SAMPLE_WIDTH)) u_fifo (
    .sample_clock (sample_clock),
    .reset_n      (reset_n),
    .push         (push),
    .push_data    (sample_in),
    .pop          (pop),
    .pop_data     (fifo_head),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  // Bit-clock divider: bclk toggles every BCLK_HALF cycles.
  always_ff @(posedge sample_clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      bclk  <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      bclk  <= ~bclk;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Next bit position, frame sample and the serial bit/channel it selects.
  always_comb begin
    // NOTE: every comb output is given a default first so no path can hold a
    // previous value, which would otherwise infer a latch.
    bit_d   = bit_q;
    frame_d = frame_q;
    if (fall)     bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
    if (boundary) frame_d = fifo_empty ? '0 : fifo_head;
    slot_pos  = (bit_d >= SLOT_LEN) ? bit_d - SLOT_LEN : bit_d;
    // Left-justify the sample in its slot, then bring bit slot_pos to the top;
    // positions past the sample width land on the zero padding.
    slot_word = (SLOT_WIDTH'(frame_d) << PAD) << slot_pos;
    sdata_d   = slot_word[SLOT_WIDTH-1];
    lr_d      = (bit_d >= LR_FIRST) && (bit_d <= LR_LAST);
  end

  // Frame state and registered serial outputs; sdata/lrclk move only on bclk falls.
  always_ff @(posedge sample_clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_q    <= BIT_LAST;
      frame_q  <= '0;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      underrun <= boundary && fifo_empty;
      if (fall) begin
        lrclk <= lr_d;
        sdata <= sdata_d;
      end
    end
  end

endmodule

// File: tb/tb_sample_serializer.sv
// tb_sample_serializer -- checks sample_serializer against a time-indexed
// model: every output is derived from the number of clock edges since reset
// and a queue of accepted samples.
module tb_sample_serializer;
  import filter_pkg::*;

  localparam int SAW        = DEFAULT_SAMPLE_WIDTH;
  localparam int SW         = DEFAULT_SLOT_WIDTH;
  localparam int BH         = 4;
  localparam int BIT_CYC    = 2 * BH;
  localparam int FRAME_BITS = 2 * SW;
  localparam int FRAME_CYC  = BIT_CYC * FRAME_BITS;

  logic    sample_clock = 1'b0;
  logic    reset_n      = 1'b1;
  sample_t sample_in    = '0;
  logic    sample_valid = 1'b0;
  logic    sample_ready;
  logic    bclk;
  logic    lrclk;
  logic    sdata;
  logic    underrun;

  always #5 sample_clock = ~sample_clock;

  sample_serializer #(
    .SAMPLE_WIDTH (SAW),
    .SLOT_WIDTH   (SW),
    .BCLK_HALF    (BH)
  ) dut (
    .sample_clock (sample_clock),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  sample_t mq[$];
  sample_t m_frame    = '0;
  logic    m_underrun = 1'b0;
  int      n_edges    = 0;
  logic    m_accept;

  function automatic bit is_fall(input int n);
    return (n >= BIT_CYC) && (n % BIT_CYC == 0);
  endfunction

  function automatic int bit_pos(input int n);
    return (n / BIT_CYC - 1) % FRAME_BITS;
  endfunction

  function automatic bit is_boundary(input int n);
    return is_fall(n) && (bit_pos(n) == 0);
  endfunction

  function automatic logic exp_bclk(input int n);
    return ((n / BH) % 2) != 0;
  endfunction

  function automatic logic exp_lr(input int n);
    int p;
    if (n < BIT_CYC) return 1'b0;
    p = bit_pos(n);
    return (p >= SW - 1) && (p <= 2 * SW - 2);
  endfunction

  function automatic logic exp_sd(input int n, input sample_t f);
    int q;
    if (n < BIT_CYC) return 1'b0;
    q = bit_pos(n) % SW;
    if (q >= SAW) return 1'b0;
    return f[SAW-1-q];
  endfunction

  // Model advances one clock edge: boundary pop first, then any accepted push.
  always @(posedge sample_clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_frame    = '0;
      m_underrun = 1'b0;
      n_edges    = 0;
    end else begin
      m_accept   = sample_valid && (mq.size() != SAMPLE_FIFO_DEPTH);
      m_underrun = 1'b0;
      if (is_boundary(n_edges + 1)) begin
        if (mq.size() > 0) m_frame = mq.pop_front();
        else begin
          m_frame    = '0;
          m_underrun = 1'b1;
        end
      end
      if (m_accept) mq.push_back(sample_in);
      n_edges = n_edges + 1;
    end
  end

  // ---------------- compare process ----------------
  logic [FRAME_BITS-1:0] cap = '0;
  logic [FRAME_BITS-1:0] cap_q[$];
  int                    urun_cnt = 0;

  always @(negedge sample_clock) begin
    check_bit("bclk",     bclk,         exp_bclk(n_edges));
    check_bit("lrclk",    lrclk,        exp_lr(n_edges));
    check_bit("sdata",    sdata,        exp_sd(n_edges, m_frame));
    check_bit("underrun", underrun,     m_underrun);
    check_bit("ready",    sample_ready, mq.size() != SAMPLE_FIFO_DEPTH);
    if (reset_n && is_fall(n_edges)) begin
      if (bit_pos(n_edges) == 0) cap = {{(FRAME_BITS-1){1'b0}}, sdata};
      else                       cap = {cap[FRAME_BITS-2:0], sdata};
      if (bit_pos(n_edges) == FRAME_BITS - 1) cap_q.push_back(cap);
    end
    if (underrun) urun_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge sample_clock);
    #2;
  endtask

  task automatic wait_edge(input int target);
    int budget = 2 * FRAME_CYC;
    while (n_edges < target && budget > 0) begin
      tick();
      budget--;
    end
    if (n_edges != target) timeout("wait_edge");
  endtask

  task automatic next_boundary();
    int budget = FRAME_CYC + 4;
    do begin
      tick();
      budget--;
    end while (!is_boundary(n_edges) && budget > 0);
    if (!is_boundary(n_edges)) timeout("next_boundary");
  endtask

  task automatic before_boundary();
    int budget = FRAME_CYC + 4;
    while (!is_boundary(n_edges + 1) && budget > 0) begin
      tick();
      budget--;
    end
    if (!is_boundary(n_edges + 1)) timeout("before_boundary");
  endtask

  task automatic wait_caps(input int cnt);
    int budget = 5 * FRAME_CYC;
    while (cap_q.size() < cnt && budget > 0) begin
      tick();
      budget--;
    end
    if (cap_q.size() < cnt) timeout("wait_caps");
  endtask

  task automatic push_one(input sample_t s);
    sample_valid = 1'b1;
    sample_in    = s;
    tick();
    sample_valid = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int budget;
    int rate;
    int rst_at;

    // Reset is asynchronous: outputs must clear before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    check_bit("rst_bclk",     bclk,         1'b0);
    check_bit("rst_lrclk",    lrclk,        1'b0);
    check_bit("rst_sdata",    sdata,        1'b0);
    check_bit("rst_underrun", underrun,     1'b0);
    check_bit("rst_ready",    sample_ready, 1'b1);
    repeat (3) tick();
    reset_n = 1'b1;

    // First frame carries a sample pushed before the first boundary.
    tick();
    push_one(24'hA50F3C);
    wait_edge(3);
    check_bit("bclk_pre_rise", bclk, 1'b0);
    wait_edge(4);
    check_bit("bclk_first_rise", bclk, 1'b1);
    wait_edge(8);
    check_bit("first_fall_bclk", bclk, 1'b0);
    check_bit("first_msb", sdata, 1'b1);
    check_bit("first_no_underrun", underrun, 1'b0);
    wait_edge(12);
    check_bit("bclk_period", bclk, 1'b1);
    wait_edge(248);
    check_bit("lrclk_p30", lrclk, 1'b0);
    wait_edge(256);
    check_bit("lrclk_p31", lrclk, 1'b1);
    wait_edge(512);
    check_bit("lrclk_p63", lrclk, 1'b0);
    wait_edge(520);
    check_bit("second_frame_underrun", underrun, 1'b1);
    wait_caps(1);
    if (cap_q.size() >= 1) check("frame_a50f3c", cap_q[0], 64'hA50F3C00_A50F3C00);

    // Idle: one underrun pulse per frame.
    next_boundary();
    tick();
    urun_cnt = 0;
    repeat (3) next_boundary();
    tick();
    check("underrun_per_frame", 64'(urun_cnt), 64'd3);

    // Three back-to-back pushes: the third waits for the next pop.
    next_boundary();
    tick();
    cap_q.delete();
    push_one(24'h111111);
    push_one(24'h222222);
    sample_valid = 1'b1;
    sample_in    = 24'h333333;
    check_bit("ready_held_off", sample_ready, 1'b0);
    budget = FRAME_CYC + 8;
    while (!sample_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!sample_ready) timeout("ready_release");
    tick();
    sample_valid = 1'b0;
    wait_caps(4);
    if (cap_q.size() >= 4) begin
      check("order_frame1", cap_q[1], 64'h11111100_11111100);
      check("order_frame2", cap_q[2], 64'h22222200_22222200);
      check("order_frame3", cap_q[3], 64'h33333300_33333300);
    end

    // Push landing on the boundary cycle while one sample is buffered.
    next_boundary();
    cap_q.delete();
    tick();
    push_one(24'h5A5A5A);
    before_boundary();
    push_one(24'hC3C3C3);
    check_bit("boundary_push_fill1", sample_ready, 1'b1);
    wait_caps(3);
    if (cap_q.size() >= 3) begin
      check("boundary_frame_x", cap_q[1], 64'h5A5A5A00_5A5A5A00);
      check("boundary_frame_y", cap_q[2], 64'hC3C3C300_C3C3C300);
    end

    // Reset in the middle of a loaded frame with a sample still buffered.
    next_boundary();
    tick();
    push_one(24'h7E8181);
    next_boundary();
    push_one(24'h3C3C3C);
    budget = FRAME_CYC;
    while (!(is_fall(n_edges) && bit_pos(n_edges) == 10) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) timeout("bit10");
    reset_n = 1'b0;
    #1;
    check_bit("midrst_bclk",  bclk,         1'b0);
    check_bit("midrst_lrclk", lrclk,        1'b0);
    check_bit("midrst_sdata", sdata,        1'b0);
    check_bit("midrst_ready", sample_ready, 1'b1);
    tick();
    tick();
    reset_n = 1'b1;
    cap_q.delete();
    wait_edge(8);
    check_bit("post_rst_underrun", underrun, 1'b1);
    check_bit("post_rst_sdata",    sdata,    1'b0);
    wait_caps(1);
    if (cap_q.size() >= 1) check("post_rst_frame", cap_q[0], 64'h0);

    // Random traffic at three push densities, with one random reset.
    rst_at = $urandom_range(200, 1400);
    for (int seg = 0; seg < 3; seg++) begin
      case (seg)
        0:       rate = 1;
        1:       rate = 300;
        default: rate = 100;
      endcase
      for (int c = 0; c < 1600; c++) begin
        sample_valid = ($urandom_range(0, rate) == 0);
        sample_in    = sample_t'($urandom);
        if (seg == 1 && c == rst_at) begin
          reset_n = 1'b0;
          tick();
          reset_n = 1'b1;
        end
        tick();
      end
    end
    sample_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
